// File: rtl/uart_pkg.sv
// Shared definitions for the digit sender: one-hot FSM states, digit geometry
// and a helper that selects one BCD nibble.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_CONVERT = 5'b00010,
    ST_SEND    = 5'b00100,
    ST_WAIT    = 5'b01000,
    ST_FIN     = 5'b10000
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int NUM_BITS   = 32;
  localparam int NUM_DIGITS = 10;

  function automatic logic [3:0] bcd_nibble(input logic [4*NUM_DIGITS-1:0] bcd,
                                            input logic [3:0] idx);
    return bcd[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, with the first
// step folded into the load edge so that done rises exactly 32 cycles after load.
module bin2bcd_seq
  import uart_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NUM_BITS-1:0]     bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam logic [5:0] LAST_ITER = 6'(NUM_BITS);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [NUM_BITS-1:0]     bin_q, bin_d;
  logic [5:0]              cnt_q;
  logic                    active_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, bin_d} = {adj, bin_q} << 1;
  end

  // On load the BCD register starts empty, so the first step is just a shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      bcd_q    <= {{(4*NUM_DIGITS-1){1'b0}}, bin[NUM_BITS-1]};
      bin_q    <= {bin[NUM_BITS-2:0], 1'b0};
      cnt_q    <= 6'd1;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST_ITER) begin
        active_q <= 1'b0;
      end else begin
        bcd_q <= bcd_d;
        bin_q <= bin_d;
        cnt_q <= cnt_q + 6'd1;
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = active_q && (cnt_q == LAST_ITER);

endmodule

// File: rtl/desconcatenador_numeros.sv
// Sends a 32-bit unsigned value as its significant decimal digits, MSD first,
// one byte per UART TX handshake, then pulses fin.
module desconcatenador_numeros
  import uart_pkg::*;
#(
  parameter bit ASCII_OUT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] valor,
  input  logic                start,
  input  logic                tx_done,
  output logic [7:0]          dato,
  output logic                tx_start,
  output logic                fin,
  output logic                busy
);

  state_e                  state_q, state_d;
  logic [3:0]              ptr_q, ptr_d, top_idx;
  logic [7:0]              dato_q, dato_d;
  logic                    load, conv_done;
  logic [4*NUM_DIGITS-1:0] bcd;

  assign load = (state_q == ST_IDLE) && start;

  bin2bcd_seq u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .bin  (valor),
    .bcd  (bcd),
    .done (conv_done)
  );

  function automatic logic [7:0] to_byte(input logic [3:0] nib);
    return {4'h0, nib} + (ASCII_OUT ? ASCII_ZERO : 8'h00);
  endfunction

  // Highest nonzero nibble; a zero value falls through to index 0 (one digit).
  always_comb begin
    top_idx = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) top_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dato_d  = dato_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (conv_done) begin
          ptr_d   = top_idx;
          dato_d  = to_byte(bcd_nibble(bcd, top_idx));
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (ptr_q != 4'd0) begin
            ptr_d   = ptr_q - 4'd1;
            dato_d  = to_byte(bcd_nibble(bcd, ptr_q - 4'd1));
            state_d = ST_SEND;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd0;
      dato_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dato_q  <= dato_d;
    end
  end

  assign dato     = dato_q;
  assign tx_start = (state_q == ST_SEND);
  assign fin      = (state_q == ST_FIN);
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_desconcatenador_numeros.sv
// Drives raw and ASCII instances with the same frames and compares every emitted
// byte and handshake against a decimal-digit model of the value sent.
module tb_desconcatenador_numeros;

  logic        clk;
  logic        reset;
  logic [31:0] valor;
  logic        start;
  logic        txDone;
  logic [7:0]  dato, datoAscii;
  logic        txStart, txStartA;
  logic        fin, finA;
  logic        busy, busyA;

  int checks      = 0;
  int failures    = 0;
  int txStartSeen = 0;
  int finSeen     = 0;
  int bothHigh    = 0;

  desconcatenador_numeros #(.ASCII_OUT(1'b0)) dut (
    .clk     (clk),
    .reset   (reset),
    .valor   (valor),
    .start   (start),
    .tx_done (txDone),
    .dato    (dato),
    .tx_start(txStart),
    .fin     (fin),
    .busy    (busy)
  );

  desconcatenador_numeros #(.ASCII_OUT(1'b1)) dutAscii (
    .clk     (clk),
    .reset   (reset),
    .valor   (valor),
    .start   (start),
    .tx_done (txDone),
    .dato    (datoAscii),
    .tx_start(txStartA),
    .fin     (finA),
    .busy    (busyA)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (txStart) txStartSeen++;
    if (fin) finSeen++;
    if (txStart && fin) bothHigh++;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: start, wait for the conversion, then answer every tx_start with
  // a tx_done 'latency' cycles later. 'disturb' injects ignored start/tx_done
  // pulses; abortAt >= 0 pulls reset low during that digit's WAIT.
  task automatic applyStimulus(input logic [31:0] value, input int latency,
                               input bit disturb, input int abortAt);
    int          digits[$];
    logic [31:0] v;
    int          cycles;
    int          startBase;
    int          finBase;
    v = value;
    digits.delete();
    do begin
      digits.push_front(int'(v % 32'd10));
      v = v / 32'd10;
    end while (v != 32'd0);
    startBase = txStartSeen;
    finBase   = finSeen;

    valor = value;
    start = 1'b1;
    tick();
    start = 1'b0;
    valor = $urandom;
    checkOutput("busyRise", 32'(busy), 32'd1);

    cycles = 1;
    while (!txStart && cycles < 100) begin
      if (disturb && cycles == 5) begin
        start  = 1'b1;
        valor  = 32'd99;
        txDone = 1'b1;
      end
      tick();
      start  = 1'b0;
      txDone = 1'b0;
      cycles++;
    end
    checkOutput("firstTxStartCycle", 32'(cycles), 32'd33);
    if (!txStart) return;

    for (int k = 0; k < digits.size(); k++) begin
      checkOutput("txStart", 32'(txStart), 32'd1);
      checkOutput("txStartAscii", 32'(txStartA), 32'd1);
      checkOutput("finDuringSend", 32'(fin), 32'd0);
      checkOutput("dato", 32'(dato), 32'(digits[k]));
      checkOutput("datoAscii", 32'(datoAscii), 32'(digits[k] + 48));
      if (disturb) txDone = 1'b1;
      for (int i = 1; i <= latency; i++) begin
        tick();
        txDone = 1'b0;
        start  = 1'b0;
        if (abortAt == k && i == 1) begin
          reset = 1'b0;
          tick();
          checkOutput("resetDato", 32'(dato), 32'd0);
          checkOutput("resetDatoAscii", 32'(datoAscii), 32'd0);
          checkOutput("resetTxStart", 32'(txStart), 32'd0);
          checkOutput("resetFin", 32'(fin), 32'd0);
          checkOutput("resetBusy", 32'(busy), 32'd0);
          reset = 1'b1;
          repeat (5) tick();
          checkOutput("noFinAfterReset", 32'(finSeen - finBase), 32'd0);
          checkOutput("idleAfterReset", 32'(busy), 32'd0);
          return;
        end
        checkOutput("txStartLow", 32'(txStart), 32'd0);
        checkOutput("datoHeld", 32'(dato), 32'(digits[k]));
        checkOutput("busyHeld", 32'(busy), 32'd1);
        txDone = (i == latency);
        if (disturb && i == 1) begin
          start = 1'b1;
          valor = 32'd99;
        end
      end
      tick();
      txDone = 1'b0;
      start  = 1'b0;
    end

    checkOutput("finPulse", 32'(fin), 32'd1);
    checkOutput("finAscii", 32'(finA), 32'd1);
    checkOutput("txStartAtFin", 32'(txStart), 32'd0);
    checkOutput("busyAtFin", 32'(busy), 32'd1);
    tick();
    checkOutput("finOnce", 32'(fin), 32'd0);
    checkOutput("busyFall", 32'(busy), 32'd0);
    checkOutput("busyFallAscii", 32'(busyA), 32'd0);
    repeat (3) tick();
    checkOutput("txStartCount", 32'(txStartSeen - startBase), 32'(digits.size()));
    checkOutput("finCount", 32'(finSeen - finBase), 32'd1);
  endtask

  initial begin
    logic [31:0] value;
    logic [31:0] lim;
    int          len;
    reset  = 1'b0;
    start  = 1'b0;
    txDone = 1'b0;
    valor  = 32'd0;
    repeat (3) tick();
    checkOutput("rstDato", 32'(dato), 32'd0);
    checkOutput("rstDatoAscii", 32'(datoAscii), 32'd0);
    checkOutput("rstTxStart", 32'(txStart), 32'd0);
    checkOutput("rstFin", 32'(fin), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    applyStimulus(32'd1234, 5, 1'b0, -1);
    applyStimulus(32'd0, 3, 1'b0, -1);
    applyStimulus(32'hFFFF_FFFF, 2, 1'b0, -1);
    applyStimulus(32'd1000000, 1, 1'b0, -1);
    applyStimulus(32'd507, 4, 1'b1, -1);
    applyStimulus(32'd321, 3, 1'b0, 1);
    applyStimulus(32'd45, 2, 1'b0, -1);

    for (int n = 0; n < 25; n++) begin
      len   = $urandom_range(1, 10);
      value = $urandom;
      if (len < 10) begin
        lim = 32'd1;
        repeat (len) lim = lim * 32'd10;
        value = value % lim;
      end
      applyStimulus(value, $urandom_range(1, 4), 1'($urandom_range(0, 1)), -1);
    end

    checkOutput("txStartFinExclusive", 32'(bothHigh), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
